// File: rtl/stream_seq_ctrl.sv
// stream_seq_ctrl
// Start/done sequencer for a pipelined datapath. A run of len_i items issues
// consecutive read addresses, follows each item through a STAGES-deep valid
// pipeline and issues the matching write-back. done_o pulses once the last
// item has been written. stall_i freezes issue and the pipeline for a cycle.
// abort_i drops the run without a done_o pulse.
module stream_seq_ctrl #(
    parameter int                ADDR_W  = 8,
    parameter int                LEN_W   = 8,
    parameter int                STAGES  = 3,
    parameter logic [ADDR_W-1:0] RD_BASE = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] WR_BASE = {ADDR_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              stall_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [STAGES-1:0] stage_vld_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1'b1);
    localparam logic [STAGES-1:0] VLD_ZERO = {STAGES{1'b0}};

    state_e            state_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_cnt_q;
    logic [LEN_W-1:0]  wr_cnt_q;
    logic [STAGES-1:0] stage_vld_q;

    logic rd_fire;
    logic wr_fire;
    logic last_rd;
    logic last_wr;

    // Issue/retire strobes and "this is the final item" detection.
    always_comb begin
        rd_fire = 1'b0;
        wr_fire = 1'b0;
        last_rd = 1'b0;
        last_wr = 1'b0;
        if (state_q == ST_RUN) begin
            rd_fire = ~stall_i;
        end else begin
            rd_fire = 1'b0;
        end
        wr_fire = stage_vld_q[STAGES-1] & ~stall_i;
        last_rd = (rd_cnt_q == (len_q - LEN_ONE));
        last_wr = (wr_cnt_q == (len_q - LEN_ONE));
    end

    // Valid pipeline: shifts one stage per unstalled cycle, holds on stall.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stage_vld_q <= VLD_ZERO;
        end else if (abort_i) begin
            stage_vld_q <= VLD_ZERO;
        end else if (!stall_i) begin
            stage_vld_q[0] <= rd_fire;
            for (int k = 1; k < STAGES; k++) begin
                stage_vld_q[k] <= stage_vld_q[k-1];
            end
        end else begin
            stage_vld_q <= stage_vld_q;
        end
    end

    // Run FSM with the length latch and the read/write item counters.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            len_q    <= LEN_ZERO;
            rd_cnt_q <= LEN_ZERO;
            wr_cnt_q <= LEN_ZERO;
        end else if (abort_i) begin
            state_q  <= ST_IDLE;
            len_q    <= LEN_ZERO;
            rd_cnt_q <= LEN_ZERO;
            wr_cnt_q <= LEN_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_q    <= len_i;
                        rd_cnt_q <= LEN_ZERO;
                        wr_cnt_q <= LEN_ZERO;
                        // An empty run still reports completion.
                        if (len_i == LEN_ZERO) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (rd_fire) begin
                        rd_cnt_q <= rd_cnt_q + LEN_ONE;
                        if (last_rd) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                    // Early items retire while later ones are still issuing.
                    if (wr_fire) begin
                        wr_cnt_q <= wr_cnt_q + LEN_ONE;
                    end else begin
                        wr_cnt_q <= wr_cnt_q;
                    end
                end
                ST_DRAIN: begin
                    if (wr_fire) begin
                        if (last_wr) begin
                            state_q  <= ST_DONE;
                            rd_cnt_q <= LEN_ZERO;
                            wr_cnt_q <= LEN_ZERO;
                        end else begin
                            state_q  <= ST_DRAIN;
                            wr_cnt_q <= wr_cnt_q + LEN_ONE;
                        end
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_q  <= ST_IDLE;
                    rd_cnt_q <= LEN_ZERO;
                    wr_cnt_q <= LEN_ZERO;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    len_q    <= LEN_ZERO;
                    rd_cnt_q <= LEN_ZERO;
                    wr_cnt_q <= LEN_ZERO;
                end
            endcase
        end
    end

    // Output decode; addresses wrap modulo 2^ADDR_W.
    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        done_o      = (state_q == ST_DONE);
        rd_en_o     = rd_fire;
        wr_en_o     = wr_fire;
        rd_addr_o   = RD_BASE + ADDR_W'(rd_cnt_q);
        wr_addr_o   = WR_BASE + ADDR_W'(wr_cnt_q);
        stage_vld_o = stage_vld_q;
    end

endmodule

// File: tb/tb_stream_seq_ctrl.sv
// Testbench for stream_seq_ctrl: two instances (default and a narrow,
// STAGES=1 wrapping variant) share stimulus and are compared every cycle
// against an item-level reference model, plus directed latency checks.
module tb_stream_seq_ctrl;

    localparam int NI = 2;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       start_i;
    logic       stall_i;
    logic       abort_i;
    logic [7:0] len_i;

    logic       busy_a, done_a, rd_en_a, wr_en_a;
    logic [7:0] rd_addr_a, wr_addr_a;
    logic [2:0] vld_a;
    logic       busy_b, done_b, rd_en_b, wr_en_b;
    logic [3:0] rd_addr_b, wr_addr_b;
    logic [0:0] vld_b;

    int n_total = 0;
    int n_pass  = 0;

    // model parameters per instance
    int p_stg[NI];
    int p_rdb[NI];
    int p_wrb[NI];
    int p_mod[NI];
    // model state: run active, done cycle, items issued/written, in-flight list
    bit m_act[NI];
    bit m_done[NI];
    int m_len[NI];
    int m_iss[NI];
    int m_wrt[NI];
    int m_n[NI];
    int m_pos[NI][8];
    int m_idx[NI][8];

    int obs_done[NI];
    int rd_log_a[$];
    int wr_log_a[$];
    int rd_log_b[$];

    stream_seq_ctrl #(.ADDR_W(8), .LEN_W(8), .STAGES(3), .RD_BASE(8'd0), .WR_BASE(8'd0)) dut_a (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .len_i(len_i),
        .stall_i(stall_i), .abort_i(abort_i), .busy_o(busy_a), .done_o(done_a),
        .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a), .stage_vld_o(vld_a),
        .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a)
    );

    stream_seq_ctrl #(.ADDR_W(4), .LEN_W(8), .STAGES(1), .RD_BASE(4'd14), .WR_BASE(4'd9)) dut_b (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .len_i(len_i),
        .stall_i(stall_i), .abort_i(abort_i), .busy_o(busy_b), .done_o(done_b),
        .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b), .stage_vld_o(vld_b),
        .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int i);
        m_act[i]  = 1'b0;
        m_done[i] = 1'b0;
        m_len[i]  = 0;
        m_iss[i]  = 0;
        m_wrt[i]  = 0;
        m_n[i]    = 0;
    endtask

    // advance the model by one clock edge using the current inputs
    task automatic model_step(input int i);
        int nn;
        int tp[8];
        int ti[8];
        nn = 0;
        if (abort_i) begin
            model_clear(i);
        end else if (m_done[i]) begin
            m_done[i] = 1'b0;
            m_act[i]  = 1'b0;
        end else if (!m_act[i]) begin
            if (start_i) begin
                m_len[i]  = int'(len_i);
                m_iss[i]  = 0;
                m_wrt[i]  = 0;
                m_n[i]    = 0;
                m_act[i]  = 1'b1;
                m_done[i] = (len_i == 8'd0);
            end
        end else if (!stall_i) begin
            for (int j = 0; j < m_n[i]; j++) begin
                if (m_pos[i][j] == p_stg[i] - 1) begin
                    m_wrt[i]++;
                end else begin
                    tp[nn] = m_pos[i][j] + 1;
                    ti[nn] = m_idx[i][j];
                    nn++;
                end
            end
            if (m_iss[i] < m_len[i]) begin
                tp[nn] = 0;
                ti[nn] = m_iss[i];
                nn++;
                m_iss[i]++;
            end
            for (int j = 0; j < nn; j++) begin
                m_pos[i][j] = tp[j];
                m_idx[i][j] = ti[j];
            end
            m_n[i] = nn;
            if (m_wrt[i] == m_len[i]) m_done[i] = 1'b1;
        end
    endtask

    task automatic check_inst(input int i, input int busy, input int done, input int rd_en,
                              input int rd_addr, input int wr_en, input int wr_addr, input int vld);
        string nm;
        int e_rd, e_wr, e_wa, e_vld;
        nm    = (i == 0) ? "a" : "b";
        e_rd  = int'(m_act[i] && !m_done[i] && (m_iss[i] < m_len[i]) && !stall_i);
        e_wr  = 0;
        e_wa  = 0;
        e_vld = 0;
        for (int j = 0; j < m_n[i]; j++) begin
            e_vld = e_vld | (1 << m_pos[i][j]);
            if (m_pos[i][j] == p_stg[i] - 1 && !stall_i) begin
                e_wr = 1;
                e_wa = (p_wrb[i] + m_idx[i][j]) % p_mod[i];
            end
        end
        check_val({nm, ".busy"}, busy, int'(m_act[i]));
        check_val({nm, ".done"}, done, int'(m_done[i]));
        check_val({nm, ".rd_en"}, rd_en, e_rd);
        check_val({nm, ".wr_en"}, wr_en, e_wr);
        check_val({nm, ".stage_vld"}, vld, e_vld);
        if (e_rd == 1) check_val({nm, ".rd_addr"}, rd_addr, (p_rdb[i] + m_iss[i]) % p_mod[i]);
        if (e_wr == 1) check_val({nm, ".wr_addr"}, wr_addr, e_wa);
    endtask

    // one clock: compare at the falling edge, step the model, return just after the rising edge
    task automatic cycle();
        @(negedge clk_i);
        obs_done[0] = int'(done_a);
        obs_done[1] = int'(done_b);
        if (rd_en_a) rd_log_a.push_back(int'(rd_addr_a));
        if (wr_en_a) wr_log_a.push_back(int'(wr_addr_a));
        if (rd_en_b) rd_log_b.push_back(int'(rd_addr_b));
        check_inst(0, int'(busy_a), int'(done_a), int'(rd_en_a), int'(rd_addr_a),
                   int'(wr_en_a), int'(wr_addr_a), int'(vld_a));
        check_inst(1, int'(busy_b), int'(done_b), int'(rd_en_b), int'(rd_addr_b),
                   int'(wr_en_b), int'(wr_addr_b), int'(vld_b));
        model_step(0);
        model_step(1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        check_val({tag, ".a.outs"}, int'({busy_a, done_a, rd_en_a, wr_en_a, vld_a}), 0);
        check_val({tag, ".a.rd_addr"}, int'(rd_addr_a), 0);
        check_val({tag, ".a.wr_addr"}, int'(wr_addr_a), 0);
        check_val({tag, ".b.outs"}, int'({busy_b, done_b, rd_en_b, wr_en_b, vld_b}), 0);
        check_val({tag, ".b.rd_addr"}, int'(rd_addr_b), 14);
        check_val({tag, ".b.wr_addr"}, int'(wr_addr_b), 9);
    endtask

    task automatic settle();
        int c;
        c = 0;
        start_i = 1'b0;
        stall_i = 1'b0;
        abort_i = 1'b0;
        while ((busy_a || busy_b) && c < 100) begin
            cycle();
            c++;
        end
        check_val("settle_timeout", int'(c < 100), 1);
    endtask

    // start a run and report the cycle (counted from the sampling edge) at which done_o appears
    task automatic run_meas(input string tag, input int len, input int s_from, input int s_to,
                            input int inst, input int exp_cyc);
        int k;
        k = 0;
        start_i = 1'b1;
        len_i   = 8'(len);
        stall_i = 1'b0;
        abort_i = 1'b0;
        cycle();
        start_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            stall_i = (c >= s_from && c <= s_to);
            cycle();
            if (obs_done[inst] == 1) begin
                k = c;
                break;
            end
        end
        stall_i = 1'b0;
        check_val(tag, k, exp_cyc);
        settle();
    endtask

    initial begin
        int nd;
        int exp_b[4];
        int exp_bb[4];
        p_stg[0] = 3;  p_rdb[0] = 0;  p_wrb[0] = 0; p_mod[0] = 256;
        p_stg[1] = 1;  p_rdb[1] = 14; p_wrb[1] = 9; p_mod[1] = 16;
        exp_b[0] = 14; exp_b[1] = 15; exp_b[2] = 0; exp_b[3] = 1;
        exp_bb[0] = 0; exp_bb[1] = 1; exp_bb[2] = 0; exp_bb[3] = 1;
        model_clear(0);
        model_clear(1);
        rstn_i  = 1'b0;
        start_i = 1'b0;
        stall_i = 1'b0;
        abort_i = 1'b0;
        len_i   = 8'd0;
        #12;
        chk_reset("reset");
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        cycle();

        // basic run, then log-based address order
        rd_log_a.delete();
        wr_log_a.delete();
        run_meas("t1.done_cycle", 4, 0, 0, 0, 8);
        check_val("t1.rd_count", rd_log_a.size(), 4);
        check_val("t1.wr_count", wr_log_a.size(), 4);
        for (int j = 0; j < 4; j++) begin
            check_val("t1.rd_order", (j < rd_log_a.size()) ? rd_log_a[j] : -1, j);
            check_val("t1.wr_order", (j < wr_log_a.size()) ? wr_log_a[j] : -1, j);
        end

        // stall in cycles 2-3
        wr_log_a.delete();
        run_meas("t2.done_cycle", 4, 2, 3, 0, 10);
        for (int j = 0; j < 4; j++) begin
            check_val("t2.wr_order", (j < wr_log_a.size()) ? wr_log_a[j] : -1, j);
        end

        // zero-length run
        run_meas("t3.done_cycle", 0, 0, 0, 0, 1);

        // abort in cycle 5, then restart
        start_i = 1'b1;
        len_i   = 8'd8;
        cycle();
        start_i = 1'b0;
        for (int c = 1; c <= 4; c++) cycle();
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        check_val("t4.idle_after_abort", int'(busy_a), 0);
        check_val("t4.vld_cleared", int'(vld_a), 0);
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            nd += obs_done[0];
        end
        check_val("t4.no_done", nd, 0);
        run_meas("t4.restart_done", 2, 0, 0, 0, 6);

        // back-to-back with start held
        rd_log_a.delete();
        start_i = 1'b1;
        len_i   = 8'd2;
        nd = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            nd += obs_done[0];
        end
        start_i = 1'b0;
        settle();
        check_val("t5.done_count", nd, 2);
        for (int j = 0; j < 4; j++) begin
            check_val("t5.rd_addr", (j < rd_log_a.size()) ? rd_log_a[j] : -1, exp_bb[j]);
        end

        // narrow instance: address wrap and single-stage latency
        rd_log_b.delete();
        run_meas("t6.done_cycle_b", 4, 0, 0, 1, 6);
        for (int j = 0; j < 4; j++) begin
            check_val("t6.rd_wrap", (j < rd_log_b.size()) ? rd_log_b[j] : -1, exp_b[j]);
        end

        // asynchronous reset in the middle of a run
        start_i = 1'b1;
        len_i   = 8'd10;
        cycle();
        start_i = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        #2;
        rstn_i = 1'b0;
        #1;
        chk_reset("t6.async_rst");
        model_clear(0);
        model_clear(1);
        cycle();
        rstn_i = 1'b1;
        cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            start_i = ($urandom_range(0, 3) != 0);
            len_i   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 5));
            stall_i = ($urandom_range(0, 6) == 0);
            abort_i = ($urandom_range(0, 80) == 0);
            cycle();
        end
        settle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
